// File: rtl/mc_controller.sv
// Multicycle controller: a Moore FSM that sequences one instruction at a time
// through fetch, decode, execute/memory and writeback. It also holds the
// condition flags {N,Z,C,V} and the registered condition-pass bit (CondEx).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (FSM to FETCH, flags and CondEx cleared)
//   Instr      instruction register contents
//   ALUFlags   {N,Z,C,V} from the ALU, captured when leaving an execute state
//   PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc               datapath enables/selects
//   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl    datapath selects
module mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_flags;
   logic        r_condex;

   logic [1:0]  w_op;
   logic        w_i;
   logic [3:0]  w_cmd;
   logic        w_s;
   logic        w_rd15;
   logic [3:0]  w_cond;
   logic        w_condex;
   logic [2:0]  w_alucontrol;
   logic        w_validcmd;
   logic        w_logicop;
   logic        w_in_execute;
   logic        w_unused_bits;

   assign w_op   = Instr[27:26];
   assign w_i    = Instr[25];
   assign w_cmd  = Instr[24:21];
   assign w_s    = Instr[20];
   assign w_rd15 = (Instr[15:12] == 4'hF);
   assign w_cond = Instr[31:28];
   assign w_unused_bits = &{1'b0, Instr[19:16], Instr[11:0]};

   assign ImmSrc = w_op;
   assign RegSrc = {w_op == 2'b01, w_op == 2'b10};

   // Condition evaluation against the registered flags {N,Z,C,V}
   always_comb begin
      w_condex = 1'b0;
      unique case (w_cond)
         4'b0000: w_condex = r_flags[2];
         4'b0001: w_condex = ~r_flags[2];
         4'b0010: w_condex = r_flags[1];
         4'b0011: w_condex = ~r_flags[1];
         4'b0100: w_condex = r_flags[3];
         4'b0101: w_condex = ~r_flags[3];
         4'b0110: w_condex = r_flags[0];
         4'b0111: w_condex = ~r_flags[0];
         4'b1000: w_condex = r_flags[1] & ~r_flags[2];
         4'b1001: w_condex = ~r_flags[1] | r_flags[2];
         4'b1010: w_condex = (r_flags[3] == r_flags[0]);
         4'b1011: w_condex = (r_flags[3] != r_flags[0]);
         4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
         4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
         4'b1110: w_condex = 1'b1;
         default: w_condex = 1'b0;
      endcase
   end

   always_comb begin
      w_alucontrol = 3'b000;
      w_validcmd   = 1'b1;
      w_logicop    = 1'b0;
      unique case (w_cmd)
         4'b0100: w_alucontrol = 3'b000;
         4'b0010: w_alucontrol = 3'b001;
         4'b0000: begin w_alucontrol = 3'b010; w_logicop = 1'b1; end
         4'b1100: begin w_alucontrol = 3'b011; w_logicop = 1'b1; end
         default: w_validcmd = 1'b0;
      endcase
   end

   assign w_in_execute = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   // Flag updates are gated by the registered CondEx, so the ALUWB that
   // follows still sees the decision made in DECODE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags  <= '0;
         r_condex <= 1'b0;
      end else begin
         if (r_state == S_DECODE)
            r_condex <= w_condex;
         if (w_in_execute && w_s && r_condex && w_validcmd) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (!w_logicop)
               r_flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   always_comb begin
      w_next     = S_FETCH;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      ResultSrc  = '0;
      ALUControl = '0;
      unique case (r_state)
         S_FETCH: begin
            w_next    = S_DECODE;
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            unique case (w_op)
               2'b01:   w_next = S_MEMADR;
               2'b10:   w_next = S_BRANCH;
               2'b00:   w_next = w_i ? S_EXECUTEI : S_EXECUTER;
               default: w_next = S_FETCH;
            endcase
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: begin
            w_next  = w_s ? S_MEMREAD : S_MEMWRITE;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            w_next = S_MEMWB;
            AdrSrc = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = r_condex;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = r_condex;
            PCWrite   = r_condex & w_rd15;
         end
         S_EXECUTER: begin
            w_next     = S_ALUWB;
            ALUControl = w_alucontrol;
         end
         S_EXECUTEI: begin
            w_next     = S_ALUWB;
            ALUSrcB    = 2'b01;
            ALUControl = w_alucontrol;
         end
         S_ALUWB: begin
            RegWrite = r_condex & w_validcmd;
            PCWrite  = r_condex & w_validcmd & w_rd15;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = r_condex;
         end
         default: w_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;

   mc_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   int unsigned nchk  = 0;
   int unsigned nfail = 0;

   // Reference model state: architectural flags and the expected per-cycle
   // output words of the instruction being run.
   logic [3:0]  mflags;
   logic [17:0] exp_q[$];
   int          exec_idx;
   logic        upd_en, upd_all;

   // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
   function automatic logic [17:0] w(input logic pcw, input logic memw, input logic regw,
                                     input logic irw, input logic adr, input logic [1:0] ra,
                                     input logic [1:0] rb, input logic [1:0] rs,
                                     input logic [2:0] alu, input logic [31:0] ins);
      logic [1:0] op;
      op = ins[27:26];
      return {pcw, memw, regw, irw, adr, op == 2'd1, op == 2'd2, ra, rb, rs, op, alu};
   endfunction

   function automatic logic [17:0] obs();
      return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
              ALUSrcB, ResultSrc, ImmSrc, ALUControl};
   endfunction

   // Condition pairs: odd codes are the complement of the even code before them
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, b;
      {n, z, cc, v} = f;
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cc;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cc & ~z;
         3'd5: b = (n == v);
         3'd6: b = ~z & (n == v);
         default: b = 1'b1;
      endcase
      return b ^ c[0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      nchk++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic build(input logic [31:0] ins);
      logic [1:0] op;
      logic       ce, valid, rd15;
      logic [2:0] alu;
      op   = ins[27:26];
      ce   = cond_ok(ins[31:28], mflags);
      rd15 = (ins[15:12] == 4'd15);
      valid = 1'b1;
      upd_all = 1'b0;
      case (ins[24:21])
         4'd4:    begin alu = 3'd0; upd_all = 1'b1; end
         4'd2:    begin alu = 3'd1; upd_all = 1'b1; end
         4'd0:    alu = 3'd2;
         4'd12:   alu = 3'd3;
         default: begin alu = 3'd0; valid = 1'b0; end
      endcase
      exp_q.delete();
      exec_idx = -1;
      upd_en = 1'b0;
      exp_q.push_back(w(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 3'd0, ins));
      exp_q.push_back(w(0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd2, 3'd0, ins));
      if (op == 2'd1) begin
         exp_q.push_back(w(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 3'd0, ins));
         if (ins[20]) begin
            exp_q.push_back(w(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, ins));
            exp_q.push_back(w(ce & rd15, 0, ce, 0, 0, 2'd0, 2'd0, 2'd1, 3'd0, ins));
         end else begin
            exp_q.push_back(w(0, ce, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, ins));
         end
      end else if (op == 2'd2) begin
         exp_q.push_back(w(ce, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, ins));
      end else if (op == 2'd0) begin
         exec_idx = 2;
         exp_q.push_back(w(0, 0, 0, 0, 0, 2'd0, ins[25] ? 2'd1 : 2'd0, 2'd0, alu, ins));
         exp_q.push_back(w(ce & valid & rd15, 0, ce & valid, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, ins));
         upd_en = ins[20] & ce & valid;
      end
   endtask

   // Entered and left in the low clock phase of the instruction's FETCH cycle.
   task automatic run_instr(input string name, input logic [31:0] ins, input logic [3:0] ef);
      build(ins);
      Instr = ins;
      for (int k = 0; k < exp_q.size(); k++) begin
         ALUFlags = (k == exec_idx) ? ef : 4'($urandom_range(0, 15));
         #1;
         chk($sformatf("%s step%0d", name, k), 32'(obs()), 32'(exp_q[k]));
         @(negedge clk);
      end
      if (upd_en) begin
         if (upd_all) mflags = ef;
         else         mflags[3:2] = ef[3:2];
      end
      chk($sformatf("%s flags", name), 32'(dut.r_flags), 32'(mflags));
   endtask

   logic [31:0] ri;
   logic [1:0]  rop;
   logic [3:0]  rcmd;
   int unsigned sel;

   initial begin
      reset = 1'b1;
      Instr = 32'hE0821003;
      ALUFlags = 4'hF;
      mflags = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset outputs", 32'(obs()), 32'(w(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 3'd0, Instr)));
      chk("reset flags", 32'(dut.r_flags), 32'h0);
      chk("reset condex", 32'(dut.r_condex), 32'h0);
      reset = 1'b0;

      run_instr("ADD", 32'hE0821003, 4'hF);
      run_instr("LDR", 32'hE5910004, 4'hF);
      run_instr("STR", 32'hE5810004, 4'hF);
      run_instr("SUBS_z1", 32'hE0500000, 4'b0100);
      chk("SUBS Z", 32'(dut.r_flags[2]), 32'h1);
      run_instr("BEQ_taken", 32'h0A000002, 4'h0);
      run_instr("SUBS_z0", 32'hE0500000, 4'b0000);
      run_instr("BEQ_not", 32'h0A000002, 4'hF);
      run_instr("ADDEQ", 32'h02811001, 4'hF);
      run_instr("ADDEQS_fail", 32'h02911001, 4'hF);
      run_instr("SUBS_z1b", 32'hE0500000, 4'b0100);
      run_instr("ADDEQS_regce", 32'h02911001, 4'b0000);
      run_instr("ADDS_cv", 32'hE0900000, 4'b0011);
      run_instr("ANDS_n", 32'hE0100000, 4'b1000);
      chk("ANDS flags", 32'(dut.r_flags), 32'hB);
      run_instr("ADD_pc", 32'hE082F003, 4'h0);
      run_instr("LDR_pc", 32'hE591F004, 4'h0);
      run_instr("EORS_inv", 32'hE0321003, 4'h5);
      run_instr("OP11", 32'hEC000000, 4'h0);
      run_instr("NV", 32'hF0821003, 4'h0);
      run_instr("ORRS", 32'hE1900000, 4'b0101);

      // Reset pulsed while in MEMREAD of a load
      build(32'hE5910004);
      Instr = 32'hE5910004;
      for (int k = 0; k < 4; k++) begin
         ALUFlags = 4'($urandom_range(0, 15));
         #1;
         chk($sformatf("LDR_abort step%0d", k), 32'(obs()), 32'(exp_q[k]));
         if (k < 3) @(negedge clk);
      end
      #1 reset = 1'b1;
      #1;
      chk("abort outputs", 32'(obs()), 32'(w(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd2, 3'd0, Instr)));
      chk("abort flags", 32'(dut.r_flags), 32'h0);
      chk("abort condex", 32'(dut.r_condex), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      mflags = '0;
      run_instr("ADD_after_rst", 32'hE0821003, 4'hF);

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         rop = (sel < 5) ? 2'd0 : (sel < 8) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
         rcmd = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 4))
            0: rcmd = 4'd4;
            1: rcmd = 4'd2;
            2: rcmd = 4'd0;
            3: rcmd = 4'd12;
            default: ;
         endcase
         ri = $urandom;
         ri[27:26] = rop;
         ri[24:21] = rcmd;
         if ($urandom_range(0, 3) == 0) ri[15:12] = 4'hF;
         run_instr($sformatf("rnd%0d", n), ri, 4'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
